// File: rtl/linebuf_win.sv
// rtl/linebuf_win.sv - 3x3 sliding-window generator over a raster pixel stream (option macro: WIN_BORDER_EN)
module linebuf_win #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB-1:0]     cfg_width,
    input  logic [YB-1:0]     cfg_height,
    input  logic [PB-1:0]     px_in_data,
    input  logic              px_in_valid,
    output logic              px_in_ready,
    output logic [9*PB-1:0]   win_data,
    output logic [XB-1:0]     win_col,
    output logic [YB-1:0]     win_row,
    output logic              win_last,
    output logic              win_valid,
    input  logic              win_ready
);
    localparam int DEPTH = 1 << XB;

    logic [XB-1:0]      col;
    logic [YB-1:0]      row;
    logic [PB-1:0]      lb0 [DEPTH];
    logic [PB-1:0]      lb1 [DEPTH];
    logic [8:0][PB-1:0] win_q;
    logic [8:0][PB-1:0] win_next;
    logic [8:0][PB-1:0] win_out;
    logic               accept;
    logic               col_wrap;
    logic               row_wrap;
    logic               emit;

    assign px_in_ready = rst & (~win_valid | win_ready);
    assign accept      = px_in_valid & px_in_ready;
    assign col_wrap    = (col == cfg_width - XB'(1));
    assign row_wrap    = (row == cfg_height - YB'(1));

    // Next window: columns slide toward j=0, the fresh tap column enters at j=2
    always_comb begin
        win_next = win_q;
        for (int i = 0; i < 3; i++) begin
            win_next[3*i]   = win_q[3*i+1];
            win_next[3*i+1] = win_q[3*i+2];
        end
        win_next[2] = lb1[col];
        win_next[5] = lb0[col];
        win_next[8] = px_in_data;
    end

`ifdef WIN_BORDER_EN
    // Zero taps left of column 0 or above row 0; this also hides columns
    // carried over from the previous row and line-buffer data of older frames
    always_comb begin
        win_out = win_next;
        for (int k = 0; k < 9; k++) begin
            if ((k % 3 == 0 && col < XB'(2)) || (k % 3 == 1 && col == '0) ||
                (k / 3 == 0 && row < YB'(2)) || (k / 3 == 1 && row == '0))
                win_out[k] = '0;
        end
    end
    assign emit = 1'b1;
`else
    assign win_out = win_next;
    assign emit    = (col >= XB'(2)) && (row >= YB'(2));
`endif

    // Line buffers: read on the current column, written on the same edge; never cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= px_in_data;
        end
    end

    // Position counters and the unmasked window shift register
    always_ff @(posedge clk) begin
        if (!rst) begin
            col   <= '0;
            row   <= '0;
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_next;
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + YB'(1);
            end else begin
                col <= col + XB'(1);
            end
        end
    end

    // Output register: loads on accept, retires on win_ready, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_col   <= '0;
            win_row   <= '0;
            win_last  <= 1'b0;
        end else if (accept) begin
            win_valid <= emit;
            win_data  <= win_out;
            win_col   <= col;
            win_row   <= row;
            win_last  <= col_wrap & row_wrap;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
